// File: rtl/equation_solver.sv
// Inverse of the E = 5A+5B-4C+3D datapath: recovers A from E, B, C using a
// one-cycle shift-add prep followed by a serial restoring divide-by-5.
module equation_solver #(
  parameter int unsigned D_CONST  = 768,
  parameter int unsigned DIV_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] E,
  input  logic [7:0]  B,
  input  logic [7:0]  C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  A,
  output logic [1:0]  err,
  output logic        busy
);

  localparam int unsigned NW = 18;
  localparam int unsigned CW = $clog2(DIV_BITS);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           e_q, e_d;
  logic [7:0]            b_q, b_d;
  logic [7:0]            c_q, c_d;
  logic [DIV_BITS-1:0]   dividend_q, dividend_d;
  logic [DIV_BITS-1:0]   quot_q, quot_d;
  logic [2:0]            rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            a_q, a_d;
  logic [1:0]            err_q, err_d;

  logic [NW-1:0]         n_c;
  logic [3:0]            rem_ext_c;
  logic                  sub_c;
  logic [2:0]            rem_nxt_c;
  logic [DIV_BITS-1:0]   quot_nxt_c;

  // Numerator in 18-bit two's complement; all terms zero-extended.
  assign n_c = NW'(e_q) - NW'({b_q, 2'b00}) - NW'(b_q)
             + NW'({c_q, 2'b00}) - NW'(3 * D_CONST);

  // One restoring-division step, MSB of the dividend first.
  assign rem_ext_c  = {rem_q, dividend_q[DIV_BITS-1]};
  assign sub_c      = (rem_ext_c >= 4'd5);
  assign rem_nxt_c  = sub_c ? 3'(rem_ext_c - 4'd5) : 3'(rem_ext_c);
  assign quot_nxt_c = {quot_q[DIV_BITS-2:0], sub_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      e_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      b_q        <= b_d;
      c_q        <= c_d;
      dividend_q <= dividend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    b_d        = b_q;
    c_d        = c_q;
    dividend_d = dividend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          e_d     = E;
          b_d     = B;
          c_d     = C;
          state_d = PREP;
        end
      end
      PREP: begin
        if (n_c[NW-1]) begin
          err_d   = 2'd1;
          a_d     = '0;
          state_d = DONE;
        end else begin
          dividend_d = DIV_BITS'(n_c);
          rem_d      = '0;
          quot_d     = '0;
          cnt_d      = '0;
          state_d    = DIV;
        end
      end
      DIV: begin
        dividend_d = {dividend_q[DIV_BITS-2:0], 1'b0};
        rem_d      = rem_nxt_c;
        quot_d     = quot_nxt_c;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_BITS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          if (|quot_nxt_c[DIV_BITS-1:8]) begin
            err_d = 2'd3;
            a_d   = '0;
          end else if (rem_nxt_c != 3'd0) begin
            err_d = 2'd2;
            a_d   = quot_nxt_c[7:0];
          end else begin
            err_d = 2'd0;
            a_d   = quot_nxt_c[7:0];
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign A         = a_q;
  assign err       = err_q;

endmodule

// File: tb/tb_equation_solver.sv
// Self-checking bench for equation_solver: directed corner cases plus random
// transactions against an arithmetic reference model.
module tb_equation_solver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] E;
  logic [7:0]  B;
  logic [7:0]  C;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  A;
  logic [1:0]  err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  equation_solver dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .E         (E),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: A = (E - 5B + 4C - 3*768) / 5 with the error precedence rules.
  task automatic model(input int e, input int b, input int c,
                       output int exp_a, output int exp_err, output int exp_lat);
    int n;
    int q;
    int r;
    n = e - 5 * b + 4 * c - 3 * 768;
    if (n < 0) begin
      exp_a = 0; exp_err = 1; exp_lat = 1;
    end else begin
      q = n / 5;
      r = n % 5;
      exp_lat = 18;
      if (q > 255) begin
        exp_a = 0; exp_err = 3;
      end else begin
        exp_a = q; exp_err = (r != 0) ? 2 : 0;
      end
    end
  endtask

  // Wait for out_valid after an accept edge; returns edges counted after accept.
  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_txn(input int e, input int b, input int c,
                         input int hold, input bit pre_ready);
    int exp_a, exp_err, exp_lat, n;
    model(e, b, c, exp_a, exp_err, exp_lat);
    @(negedge clk);
    E = 16'(e); B = 8'(b); C = 8'(c);
    in_valid  = 1'b1;
    out_ready = pre_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_busy", busy, 1);
    wait_result(n);
    check("latency", n, exp_lat);
    check("A", A, exp_a);
    check("err", err, exp_err);
    check("in_ready_done", in_ready, 0);
    if (!pre_ready) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_A", A, exp_a);
        check("hold_err", err, exp_err);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovalid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int n, exp_a, exp_err, exp_lat, cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; E = '0; B = '0; C = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_A", A, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn(2334, 20, 30, 0, 1'b0);
    run_txn(4854, 255, 0, 1, 1'b0);
    run_txn(0, 0, 0, 0, 1'b0);
    run_txn(2335, 20, 30, 2, 1'b0);
    run_txn(65535, 0, 255, 0, 1'b0);
    run_txn(2304, 0, 0, 0, 1'b0);
    run_txn(2334, 20, 30, 0, 1'b1);
    run_txn(100, 0, 255, 0, 1'b1);

    // Backpressure with a second request held against DONE.
    @(negedge clk);
    E = 16'd2334; B = 8'd20; C = 8'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(n);
    check("bp_latency", n, 18);
    E = 16'd4854; B = 8'd255; C = 8'd0; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_A", A, 10);
      check("bp_err", err, 0);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_in_ready_rise", in_ready, 1);
    check("bp_valid_drop", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_busy", busy, 1);
    wait_result(n);
    check("bp2_latency", n, 18);
    check("bp2_A", A, 255);
    check("bp2_err", err, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp2_done", in_ready, 1);

    // Asynchronous reset in the middle of the divide.
    @(negedge clk);
    E = 16'd2334; B = 8'd20; C = 8'd30; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_A", A, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("mid_rst_no_valid", cnt, 0);
    run_txn(2335, 20, 30, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int b, c, e, a, mode;
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        e = $urandom_range(0, 65535);
      end else begin
        a = $urandom_range(0, 255);
        e = 5 * a + 5 * b - 4 * c + 2304 + ((mode == 1) ? $urandom_range(0, 4) : 0);
      end
      run_txn(e, b, c, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    model(0, 0, 0, exp_a, exp_err, exp_lat);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
